// File: rtl/watchdog_reset_pkg.sv
// Shared definitions for the watchdog reset block.
// State encoding and default service key.
package watchdog_reset_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_WARN     = 2'd2,
        ST_BITE     = 2'd3
    } wd_state_t;

    localparam logic [7:0] KEY_DEFAULT = 8'hA5;

endpackage

// File: rtl/wd_pulse_stretch.sv
// Holds the reset request low for PULSE_LEN cycles after start.
// done marks the last low cycle; resetn releases on the next edge.
module wd_pulse_stretch #(
    parameter int PULSE_LEN = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic start,
    output logic busy,
    output logic done,
    output logic resetn
);

    logic [7:0] cnt_q;
    logic       resetn_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q    <= '0;
            resetn_q <= 1'b1;
        end else if (start) begin
            cnt_q    <= 8'(PULSE_LEN - 1);
            resetn_q <= 1'b0;
        end else if (!resetn_q) begin
            if (cnt_q == 8'd0) begin
                resetn_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign busy   = !resetn_q;
    assign done   = !resetn_q && (cnt_q == 8'd0);
    assign resetn = resetn_q;

endmodule

// File: rtl/watchdog_reset.sv
// Watchdog: converts missed heartbeat kicks into a timed reset request.
// Status (bite_count, bad_key) only clears on RESET, never on a bite.
module watchdog_reset
    import watchdog_reset_pkg::*;
#(
    parameter int         CNT_W       = 16,
    parameter int         WARN_CYCLES = 64,
    parameter int         PULSE_LEN   = 8,
    parameter logic [7:0] KEY         = KEY_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             enable,
    input  logic [CNT_W-1:0] timeout_load,
    input  logic             kick_valid,
    input  logic [7:0]       kick_data,
    output logic             kick_ready,
    output logic             wd_resetn,
    output logic             warn,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic [7:0]       bite_count,
    output logic             bad_key
);

    localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_CYCLES);

    wd_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] eff_load;
    logic [CNT_W-1:0] count_dec;
    logic             warn_q;
    logic [7:0]       bites_q;
    logic             bad_q, bad_d;
    logic             kick_acc, kick_good, kick_bad;
    logic             bite_start;
    logic             pulse_busy, pulse_done;

    assign kick_ready = (state_q != ST_BITE);
    assign kick_acc   = kick_valid && kick_ready;
    assign kick_good  = kick_acc && (kick_data == KEY);
    assign kick_bad   = kick_acc && (kick_data != KEY);
    assign eff_load   = (timeout_load == '0) ? CNT_W'(1) : timeout_load;
    assign count_dec  = count_q - CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        bad_d      = bad_q;
        bite_start = 1'b0;
        unique case (state_q)
            ST_DISABLED: begin
                if (enable) begin
                    count_d = eff_load;
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING, ST_WARN: begin
                // Bad key beats disable; disable beats kick and timeout.
                if (kick_bad) begin
                    bad_d      = 1'b1;
                    state_d    = ST_BITE;
                    bite_start = 1'b1;
                end else if (!enable) begin
                    count_d = '0;
                    state_d = ST_DISABLED;
                end else if (kick_good) begin
                    count_d = eff_load;
                    state_d = (eff_load <= WARN_C) ? ST_WARN : ST_RUNNING;
                end else if (count_q == '0) begin
                    state_d    = ST_BITE;
                    bite_start = 1'b1;
                end else begin
                    count_d = count_dec;
                    if (count_dec <= WARN_C) begin
                        state_d = ST_WARN;
                    end
                end
            end
            ST_BITE: begin
                if (pulse_busy && pulse_done) begin
                    if (enable) begin
                        count_d = eff_load;
                        state_d = ST_RUNNING;
                    end else begin
                        count_d = '0;
                        state_d = ST_DISABLED;
                    end
                end
            end
            default: state_d = ST_DISABLED;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_DISABLED;
            count_q <= '0;
            warn_q  <= 1'b0;
            bites_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            warn_q  <= (state_d == ST_WARN);
            bad_q   <= bad_d;
            if (bite_start && bites_q != 8'hFF) begin
                bites_q <= bites_q + 8'd1;
            end
        end
    end

    wd_pulse_stretch #(
        .PULSE_LEN(PULSE_LEN)
    ) u_pulse (
        .CLK   (CLK),
        .RESET (RESET),
        .start (bite_start),
        .busy  (pulse_busy),
        .done  (pulse_done),
        .resetn(wd_resetn)
    );

    assign warn       = warn_q;
    assign count      = count_q;
    assign state      = state_q;
    assign bite_count = bites_q;
    assign bad_key    = bad_q;

endmodule

// File: tb/tb_watchdog_reset.sv
// Directed bench for watchdog_reset with hand-computed expectations.
// Inputs change 1ns after posedge; outputs checked at the same point.
module tb_watchdog_reset;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        enable;
    logic [15:0] timeout_load;
    logic        kick_valid;
    logic [7:0]  kick_data;
    logic        kick_ready;
    logic        wd_resetn;
    logic        warn;
    logic [15:0] count;
    logic [1:0]  state;
    logic [7:0]  bite_count;
    logic        bad_key;

    int n_checks = 0;
    int n_fails  = 0;
    logic seen_low, seen_warn;

    watchdog_reset dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .enable      (enable),
        .timeout_load(timeout_load),
        .kick_valid  (kick_valid),
        .kick_data   (kick_data),
        .kick_ready  (kick_ready),
        .wd_resetn   (wd_resetn),
        .warn        (warn),
        .count       (count),
        .state       (state),
        .bite_count  (bite_count),
        .bad_key     (bad_key)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        RESET        = 1'b0;
        enable       = 1'b0;
        timeout_load = 16'd0;
        kick_valid   = 1'b0;
        kick_data    = 8'h00;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_wd", 32'(wd_resetn), 32'd1);
        check("rst_warn", 32'(warn), 32'd0);
        check("rst_bites", 32'(bite_count), 32'd0);
        check("rst_bad", 32'(bad_key), 32'd0);
        check("rst_ready", 32'(kick_ready), 32'd1);
        #1 RESET = 1'b1;
        tick(2);
        check("dis_idle", 32'(state), 32'd0);

        // Arm with 10, no kicks
        timeout_load = 16'd10;
        enable       = 1'b1;
        tick();
        check("arm_state", 32'(state), 32'd1);
        check("arm_count", 32'(count), 32'd10);
        check("arm_warn", 32'(warn), 32'd0);
        tick();
        check("e1_state", 32'(state), 32'd2);
        check("e1_count", 32'(count), 32'd9);
        check("e1_warn", 32'(warn), 32'd1);
        tick(9);
        check("e10_count", 32'(count), 32'd0);
        check("e10_wd", 32'(wd_resetn), 32'd1);
        tick();
        check("e11_wd", 32'(wd_resetn), 32'd0);
        check("e11_state", 32'(state), 32'd3);
        check("e11_warn", 32'(warn), 32'd0);
        check("e11_bites", 32'(bite_count), 32'd1);
        check("e11_ready", 32'(kick_ready), 32'd0);
        tick(7);
        check("e18_wd", 32'(wd_resetn), 32'd0);
        tick();
        check("e19_wd", 32'(wd_resetn), 32'd1);
        check("e19_state", 32'(state), 32'd1);
        check("e19_count", 32'(count), 32'd10);

        // Load 200, kick every 100 cycles
        timeout_load = 16'd200;
        seen_low     = 1'b0;
        seen_warn    = 1'b0;
        kick_data    = 8'hA5;
        for (int i = 0; i < 2000; i++) begin
            kick_valid = (i % 100 == 0);
            tick();
            seen_low  = seen_low | !wd_resetn;
            seen_warn = seen_warn | warn;
        end
        kick_valid = 1'b0;
        check("hb_low", 32'(seen_low), 32'd0);
        check("hb_warn", 32'(seen_warn), 32'd0);
        check("hb_bites", 32'(bite_count), 32'd1);
        check("hb_count", 32'(count), 32'd101);
        check("hb_state", 32'(state), 32'd1);

        // Wrong key bites at once
        kick_valid = 1'b1;
        kick_data  = 8'h5A;
        tick();
        kick_valid = 1'b0;
        check("bk_wd", 32'(wd_resetn), 32'd0);
        check("bk_bad", 32'(bad_key), 32'd1);
        check("bk_state", 32'(state), 32'd3);
        check("bk_ready", 32'(kick_ready), 32'd0);
        check("bk_bites", 32'(bite_count), 32'd2);
        tick(7);
        check("bk_ready7", 32'(kick_ready), 32'd0);
        tick();
        check("bk_ready8", 32'(kick_ready), 32'd1);
        check("bk_wd8", 32'(wd_resetn), 32'd1);
        check("bk_count8", 32'(count), 32'd200);

        // Good kick exactly at count==0
        timeout_load = 16'd3;
        kick_valid   = 1'b1;
        kick_data    = 8'hA5;
        tick();
        kick_valid = 1'b0;
        check("k3_state", 32'(state), 32'd2);
        check("k3_warn", 32'(warn), 32'd1);
        tick(3);
        check("k0_count", 32'(count), 32'd0);
        timeout_load = 16'd100;
        kick_valid   = 1'b1;
        tick();
        kick_valid = 1'b0;
        check("k0_reload", 32'(count), 32'd100);
        check("k0_state", 32'(state), 32'd1);
        check("k0_warn", 32'(warn), 32'd0);
        check("k0_wd", 32'(wd_resetn), 32'd1);

        // Drop enable in WARN
        tick(36);
        check("w_count", 32'(count), 32'd64);
        check("w_state", 32'(state), 32'd2);
        enable = 1'b0;
        tick();
        check("wd_state", 32'(state), 32'd0);
        check("wd_count", 32'(count), 32'd0);
        check("wd_warn", 32'(warn), 32'd0);

        // Drop enable during BITE
        timeout_load = 16'd2;
        enable       = 1'b1;
        tick(4);
        check("eb_wd", 32'(wd_resetn), 32'd0);
        enable = 1'b0;
        tick(7);
        check("eb_state7", 32'(state), 32'd3);
        check("eb_wd7", 32'(wd_resetn), 32'd0);
        tick();
        check("eb_state8", 32'(state), 32'd0);
        check("eb_wd8", 32'(wd_resetn), 32'd1);
        check("eb_bites", 32'(bite_count), 32'd3);

        // Zero load bites on 2nd edge, then reset mid-bite
        timeout_load = 16'd0;
        enable       = 1'b1;
        tick();
        check("z_count", 32'(count), 32'd1);
        tick();
        check("z_wd1", 32'(wd_resetn), 32'd1);
        tick();
        check("z_wd2", 32'(wd_resetn), 32'd0);
        check("z_bites", 32'(bite_count), 32'd4);
        tick(3);
        #2 RESET = 1'b0;
        #1;
        check("ar_wd", 32'(wd_resetn), 32'd1);
        check("ar_bites", 32'(bite_count), 32'd0);
        check("ar_bad", 32'(bad_key), 32'd0);
        check("ar_state", 32'(state), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        RESET = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
